// File: rtl/program_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : program_run_ctrl
// Purpose  : Program-run sequencer for a single-cycle RV32I core. Holds the
//            core in reset while a program is streamed into instruction
//            memory, then releases it, counts executed cycles and stops on
//            a halt instruction or a cycle limit.
// Revision : 1.0 - initial release
// ============================================================================
module program_run_ctrl #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    CNT_WIDTH  = 16,
    parameter logic [DATA_WIDTH-1:0] HALT_INSTR = 32'h0000006F
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  cycle_limit,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_waddr,
    output logic [DATA_WIDTH-1:0] imem_wdata,
    output logic                  core_arst_n,
    input  logic [DATA_WIDTH-1:0] instruction,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout,
    output logic                  overflow,
    output logic [CNT_WIDTH-1:0]  cycle_count,
    output logic [ADDR_WIDTH:0]   word_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [ADDR_WIDTH:0]   r_word_count;
    logic [CNT_WIDTH-1:0]  r_cycle_count;
    logic [CNT_WIDTH-1:0]  r_limit;
    logic                  r_timeout;
    logic                  r_overflow;
    logic                  r_core_rst_n;

    logic                  w_beat;
    logic                  w_last_addr;
    logic                  w_halt;
    logic [CNT_WIDTH-1:0]  w_cnt_inc;
    logic                  w_limit_hit;
    logic                  w_cnt_sat;

    // Handshake, halt detection and limit comparison for the current cycle
    always_comb begin
        w_beat      = (r_state == S_LOAD) && s_valid;
        w_last_addr = (r_ptr == {ADDR_WIDTH{1'b1}});
        w_halt      = (instruction == HALT_INSTR);
        w_cnt_inc   = r_cycle_count + CNT_WIDTH'(1);
        w_limit_hit = (r_limit != '0) && (w_cnt_inc == r_limit);
        w_cnt_sat   = &r_cycle_count;
    end

    // Sequencer state, counters, flags and the registered core reset
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state       <= S_IDLE;
            r_ptr         <= '0;
            r_word_count  <= '0;
            r_cycle_count <= '0;
            r_limit       <= '0;
            r_timeout     <= 1'b0;
            r_overflow    <= 1'b0;
            r_core_rst_n  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state       <= S_LOAD;
                        r_ptr         <= '0;
                        r_word_count  <= '0;
                        r_cycle_count <= '0;
                        r_limit       <= cycle_limit;
                        r_timeout     <= 1'b0;
                        r_overflow    <= 1'b0;
                        r_core_rst_n  <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (s_valid) begin
                        r_ptr        <= r_ptr + ADDR_WIDTH'(1);
                        r_word_count <= r_word_count + (ADDR_WIDTH+1)'(1);
                        if (s_last) begin
                            // Core leaves reset on the same edge so it fetches
                            // PC 0 during the first RUN cycle.
                            r_state      <= S_RUN;
                            r_core_rst_n <= 1'b1;
                        end else if (w_last_addr) begin
                            // Memory is full and the program is not finished:
                            // abort without ever releasing the core.
                            r_overflow <= 1'b1;
                            r_state    <= S_DONE;
                        end
                    end
                end
                S_RUN: begin
                    if (!w_cnt_sat) begin
                        r_cycle_count <= w_cnt_inc;
                    end
                    if (w_halt) begin
                        r_state <= S_DONE;
                    end else if (w_limit_hit) begin
                        r_timeout <= 1'b1;
                        r_state   <= S_DONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Output decode: write port is a zero-latency pass-through during LOAD
    always_comb begin
        s_ready     = (r_state == S_LOAD);
        imem_we     = w_beat;
        imem_waddr  = r_ptr;
        imem_wdata  = s_data;
        core_arst_n = r_core_rst_n;
        busy        = (r_state == S_LOAD) || (r_state == S_RUN);
        done        = (r_state == S_DONE);
        timeout     = r_timeout;
        overflow    = r_overflow;
        cycle_count = r_cycle_count;
        word_count  = r_word_count;
    end

endmodule
`default_nettype wire

// File: tb/tb_program_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_program_run_ctrl
// Purpose  : Table-driven bench for program_run_ctrl with a small behavioural
//            RV32I core (addi/add/beq/jal) attached to the imem write port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_program_run_ctrl;

    localparam logic [31:0] C_ADDI_X1_5  = 32'h00500093; // addi x1,x0,5
    localparam logic [31:0] C_ADD_X2     = 32'h00108133; // add  x2,x1,x1
    localparam logic [31:0] C_HALT       = 32'h0000006F; // jal  x0,0
    localparam logic [31:0] C_ADDI_X1_1  = 32'h00100093; // addi x1,x0,1
    localparam logic [31:0] C_INC_X1     = 32'h00108093; // addi x1,x1,1
    localparam logic [31:0] C_BEQ_BACK   = 32'hFE000EE3; // beq  x0,x0,-4
    localparam logic [31:0] C_NOP        = 32'h00000013; // addi x0,x0,0

    logic        clk = 1'b0;
    logic        arst_n;
    logic        start;
    logic [15:0] cycle_limit;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        s_last;
    logic        imem_we;
    logic [7:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic        core_arst_n;
    logic [31:0] instruction;
    logic        busy;
    logic        done;
    logic        timeout;
    logic        overflow;
    logic [15:0] cycle_count;
    logic [8:0]  word_count;

    always #5 clk = ~clk;

    program_run_ctrl dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .start       (start),
        .cycle_limit (cycle_limit),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_last      (s_last),
        .imem_we     (imem_we),
        .imem_waddr  (imem_waddr),
        .imem_wdata  (imem_wdata),
        .core_arst_n (core_arst_n),
        .instruction (instruction),
        .busy        (busy),
        .done        (done),
        .timeout     (timeout),
        .overflow    (overflow),
        .cycle_count (cycle_count),
        .word_count  (word_count)
    );

    // ---------------- behavioural memory + core -----------------------------
    logic [31:0] mem [0:255];
    logic [31:0] rf  [0:31];
    logic [31:0] pc;
    logic [31:0] ins;
    logic [31:0] imm_i, imm_b, imm_j;
    logic [4:0]  rd, rs1, rs2;

    assign ins         = mem[pc[9:2]];
    assign instruction = ins;
    assign rd    = ins[11:7];
    assign rs1   = ins[19:15];
    assign rs2   = ins[24:20];
    assign imm_i = {{20{ins[31]}}, ins[31:20]};
    assign imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    assign imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};

    always @(posedge clk) begin
        if (imem_we) mem[imem_waddr] <= imem_wdata;
    end

    always @(posedge clk or negedge core_arst_n) begin
        if (!core_arst_n) begin
            pc <= 32'd0;
            for (int r = 0; r < 32; r++) rf[r] <= 32'd0;
        end else begin
            case (ins[6:0])
                7'h13: begin
                    if (rd != 5'd0) rf[rd] <= rf[rs1] + imm_i;
                    pc <= pc + 32'd4;
                end
                7'h33: begin
                    if (rd != 5'd0) rf[rd] <= rf[rs1] + rf[rs2];
                    pc <= pc + 32'd4;
                end
                7'h63: pc <= (ins[14:12] == 3'd0 && rf[rs1] == rf[rs2]) ? pc + imm_b : pc + 32'd4;
                7'h6F: begin
                    if (rd != 5'd0) rf[rd] <= pc + 32'd4;
                    pc <= pc + imm_j;
                end
                default: pc <= pc + 32'd4;
            endcase
        end
    end

    // ---------------- monitors (cumulative, snapshotted by tests) -----------
    int          wr_total  = 0;
    int          bad_we    = 0;
    int          rel_total = 0;
    logic [7:0]  wlog [0:1023];

    always @(posedge clk) begin
        if (imem_we) begin
            wlog[wr_total % 1024] = imem_waddr;
            wr_total = wr_total + 1;
            if (!s_valid) bad_we = bad_we + 1;
        end
        if (core_arst_n === 1'b1) rel_total = rel_total + 1;
    end

    // ---------------- checking ----------------------------------------------
    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, ".s_ready"},     32'(s_ready),     32'd0);
        chk({tag, ".imem_we"},     32'(imem_we),     32'd0);
        chk({tag, ".busy"},        32'(busy),        32'd0);
        chk({tag, ".done"},        32'(done),        32'd0);
        chk({tag, ".timeout"},     32'(timeout),     32'd0);
        chk({tag, ".overflow"},    32'(overflow),    32'd0);
        chk({tag, ".core_arst_n"}, 32'(core_arst_n), 32'd0);
        chk({tag, ".cycle_count"}, 32'(cycle_count), 32'd0);
        chk({tag, ".word_count"},  32'(word_count),  32'd0);
    endtask

    // ---------------- vector table ------------------------------------------
    typedef struct {
        logic [15:0]      limit;
        int               n;
        logic [5:0][31:0] w;
        int               gap;
        logic             exp_to;
        logic [15:0]      exp_cc;
        logic             chk_x2;
    } vec_t;

    localparam int NV = 7;
    vec_t vt [NV];

    // Pulse start, stream the program, leave inputs idle after the last beat.
    task automatic load_prog(input int idx, input logic [15:0] lim, output int wbase);
        @(negedge clk);
        cycle_limit = lim;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wbase = wr_total;
        chk($sformatf("v%0d.load_busy", idx),  32'(busy),        32'd1);
        chk($sformatf("v%0d.load_ready", idx), 32'(s_ready),     32'd1);
        chk($sformatf("v%0d.load_core", idx),  32'(core_arst_n), 32'd0);
        for (int i = 0; i < vt[idx].n; i++) begin
            s_valid = 1'b0;
            repeat (vt[idx].gap) @(negedge clk);
            s_valid = 1'b1;
            s_data  = vt[idx].w[i];
            s_last  = (i == vt[idx].n - 1);
            @(negedge clk);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (done !== 1'b1 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk({tag, ".done"}, 32'(done), 32'd1);
    endtask

    task automatic run_vec(input int idx);
        int    wbase;
        int    bad_before;
        int    addr_bad;
        string t;
        t = $sformatf("v%0d", idx);
        bad_before = bad_we;
        load_prog(idx, vt[idx].limit, wbase);
        wait_done(t);
        addr_bad = 0;
        for (int i = 0; i < vt[idx].n; i++)
            if (wlog[(wbase + i) % 1024] !== 8'(i)) addr_bad++;
        chk({t, ".busy"},        32'(busy),                  32'd0);
        chk({t, ".timeout"},     32'(timeout),               32'(vt[idx].exp_to));
        chk({t, ".overflow"},    32'(overflow),              32'd0);
        chk({t, ".cycle_count"}, 32'(cycle_count),           32'(vt[idx].exp_cc));
        chk({t, ".word_count"},  32'(word_count),            32'(vt[idx].n));
        chk({t, ".writes"},      32'(wr_total - wbase),      32'(vt[idx].n));
        chk({t, ".addr_order"},  32'(addr_bad),              32'd0);
        chk({t, ".idle_writes"}, 32'(bad_we - bad_before),   32'd0);
        chk({t, ".core_held"},   32'(core_arst_n),           32'd1);
        if (vt[idx].chk_x2) chk({t, ".x2"}, rf[2], 32'd10);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int wbase;
        int rel0;
        int addr_bad;

        // limit, n, words, gap, timeout, cycles, check x2
        vt[0] = '{16'd0,  3, {96'd0, C_HALT, C_ADD_X2, C_ADDI_X1_5}, 0, 1'b0, 16'd3,  1'b1};
        vt[1] = '{16'd20, 4, {64'd0, C_HALT, C_BEQ_BACK, C_INC_X1, C_ADDI_X1_1}, 0, 1'b1, 16'd20, 1'b0};
        vt[2] = '{16'd1,  1, {160'd0, C_HALT}, 0, 1'b0, 16'd1, 1'b0};
        vt[3] = '{16'd0,  5, {32'd0, C_HALT, C_NOP, C_NOP, C_ADD_X2, C_ADDI_X1_5}, 2, 1'b0, 16'd5, 1'b1};
        vt[4] = '{16'd3,  3, {96'd0, C_HALT, C_ADD_X2, C_ADDI_X1_5}, 0, 1'b0, 16'd3,  1'b1};
        vt[5] = '{16'd4,  3, {96'd0, C_HALT, C_ADD_X2, C_ADDI_X1_5}, 0, 1'b0, 16'd3,  1'b1};
        vt[6] = '{16'd0,  2, {128'd0, C_HALT, C_ADDI_X1_5}, 0, 1'b0, 16'd2, 1'b0};

        arst_n      = 1'b0;
        start       = 1'b0;
        cycle_limit = 16'd0;
        s_valid     = 1'b0;
        s_data      = 32'd0;
        s_last      = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outs("reset");
        arst_n = 1'b1;

        for (int v = 0; v < 6; v++) run_vec(v);

        // Overflow: 256 beats without s_last fills memory and aborts.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wbase = wr_total;
        rel0  = rel_total;
        for (int i = 0; i < 256; i++) begin
            s_valid = 1'b1;
            s_data  = C_NOP;
            s_last  = 1'b0;
            @(negedge clk);
        end
        s_valid = 1'b0;
        wait_done("ovf");
        addr_bad = 0;
        for (int i = 0; i < 256; i++)
            if (wlog[(wbase + i) % 1024] !== 8'(i)) addr_bad++;
        chk("ovf.overflow",    32'(overflow),          32'd1);
        chk("ovf.timeout",     32'(timeout),           32'd0);
        chk("ovf.writes",      32'(wr_total - wbase),  32'd256);
        chk("ovf.addr_order",  32'(addr_bad),          32'd0);
        chk("ovf.word_count",  32'(word_count),        32'd256);
        chk("ovf.cycle_count", 32'(cycle_count),       32'd0);
        chk("ovf.core_never",  32'(rel_total - rel0),  32'd0);
        chk("ovf.core_low",    32'(core_arst_n),       32'd0);

        // Mid-RUN reset, with an ignored start pulse during RUN.
        load_prog(1, 16'd0, wbase);
        chk("mid.run_core", 32'(core_arst_n), 32'd1);
        for (int c = 1; c <= 7; c++) begin
            start = (c == 3);
            @(negedge clk);
        end
        start = 1'b0;
        chk("mid.busy",        32'(busy),        32'd1);
        chk("mid.word_count",  32'(word_count),  32'd4);
        chk("mid.cycle_count", 32'(cycle_count), 32'd7);
        arst_n = 1'b0;
        #1;
        chk_reset_outs("mid_rst");
        @(negedge clk);
        arst_n = 1'b1;
        run_vec(6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
